// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the N-bit arbitrated mux.
package arb_mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping M-1 -> 0.
module rr_priority_pick #(
   parameter int M    = 4,
   parameter int SELW = 2
) (
   input  logic [M-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [SELW-1:0] gnt_idx,
   output logic            gnt_any
);

   int idx;

   // Walk from the farthest candidate back to ptr so the nearest request wins.
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int k = M - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= M) idx = idx - M;
         if (req[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = SELW'(idx);
         end
      end
   end

endmodule

// File: rtl/n_bit_arb_mux.sv
// M-input, N-bit registered mux with valid/ready handshakes, fixed or round-robin select.
// Optional burst lock enabled by defining ARB_MUX_LOCK_EN.
module n_bit_arb_mux
   import arb_mux_pkg::*;
#(
   parameter  int N    = 32,
   parameter  int M    = 4,
   localparam int SELW = clog2(M)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mode,
   input  logic [SELW-1:0] sel,
   input  logic [M*N-1:0]  in_data,
   input  logic [M-1:0]    in_valid,
   output logic [M-1:0]    in_ready,
   output logic [N-1:0]    out_data,
   output logic            out_valid,
   input  logic            out_ready,
`ifdef ARB_MUX_LOCK_EN
   input  logic            lock,
`endif
   output logic [SELW-1:0] out_src
);

   logic            load;
   logic            xfer;
   logic            gnt_any;
   logic            rr_any;
   logic [SELW-1:0] g;
   logic [SELW-1:0] rr_idx;
   logic [SELW-1:0] ptr;

`ifdef ARB_MUX_LOCK_EN
   logic            locked;
   logic            rr_seen;
   logic [SELW-1:0] last_src;

   assign locked = (mode == MODE_RR) & lock & rr_seen;
`endif

   assign load = ~out_valid | out_ready;

   rr_priority_pick #(
      .M    (M),
      .SELW (SELW)
   ) u_pick (
      .req     (in_valid),
      .ptr     (ptr),
      .gnt_idx (rr_idx),
      .gnt_any (rr_any)
   );

   always_comb begin
      g       = '0;
      gnt_any = 1'b0;
      if (mode == MODE_FIXED) begin
         g       = sel;
         gnt_any = (int'(sel) < M);
      end
`ifdef ARB_MUX_LOCK_EN
      else if (locked) begin
         // Burst hold: stay on the last round-robin winner even if it idles.
         g       = last_src;
         gnt_any = 1'b1;
      end
`endif
      else begin
         g       = rr_idx;
         gnt_any = rr_any;
      end
   end

   // Fixed mode offers ready on sel regardless of that channel's valid.
   always_comb begin
      in_ready = '0;
      if (rst && load && gnt_any) in_ready[g] = 1'b1;
   end

   assign xfer = |(in_valid & in_ready);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         ptr       <= '0;
`ifdef ARB_MUX_LOCK_EN
         last_src  <= '0;
         rr_seen   <= 1'b0;
`endif
      end else if (xfer) begin
         out_data  <= in_data[int'(g)*N +: N];
         out_src   <= g;
         out_valid <= 1'b1;
`ifdef ARB_MUX_LOCK_EN
         if (mode == MODE_RR) begin
            last_src <= g;
            rr_seen  <= 1'b1;
         end
         if (mode == MODE_RR && !locked)
            ptr <= (int'(g) == M - 1) ? '0 : g + SELW'(1);
`else
         if (mode == MODE_RR)
            ptr <= (int'(g) == M - 1) ? '0 : g + SELW'(1);
`endif
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_n_bit_arb_mux.sv
// Scoreboard bench for n_bit_arb_mux: an M=4 instance and an M=3 instance share clock and reset.
module tb_n_bit_arb_mux;

   typedef struct {
      logic [1:0]  src;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;

   logic        m4, ordy4, ov4;
   logic [1:0]  sel4, src4;
   logic [3:0]  vld4, rdy4;
   logic [127:0] din4;
   logic [31:0] dout4;

   logic        m3, ordy3, ov3;
   logic [1:0]  sel3, src3;
   logic [2:0]  vld3, rdy3;
   logic [95:0] din3;
   logic [31:0] dout3;

`ifdef ARB_MUX_LOCK_EN
   logic        lock;
`endif

   logic [31:0] d4 [4];
   logic [31:0] d3 [3];
   exp_t        sb4 [$];
   exp_t        sb3 [$];
   exp_t        e4, e3;
   int          n_chk  = 0;
   int          n_pass = 0;

   always #5 clk = ~clk;

   n_bit_arb_mux #(.N(32), .M(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .mode      (m4),
      .sel       (sel4),
      .in_data   (din4),
      .in_valid  (vld4),
      .in_ready  (rdy4),
      .out_data  (dout4),
      .out_valid (ov4),
      .out_ready (ordy4),
`ifdef ARB_MUX_LOCK_EN
      .lock      (lock),
`endif
      .out_src   (src4)
   );

   n_bit_arb_mux #(.N(32), .M(3)) u_dut3 (
      .clk       (clk),
      .rst       (rst),
      .mode      (m3),
      .sel       (sel3),
      .in_data   (din3),
      .in_valid  (vld3),
      .in_ready  (rdy3),
      .out_data  (dout3),
      .out_valid (ov3),
      .out_ready (ordy3),
`ifdef ARB_MUX_LOCK_EN
      .lock      (1'b0),
`endif
      .out_src   (src3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // Monitors: a word is taken at the next rising edge when out_valid & out_ready.
   always @(negedge clk) begin
      if (rst === 1'b1 && ov4 && ordy4) begin
         if (sb4.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_word4: got src %0d data %h, expected none", src4, dout4);
         end else begin
            e4 = sb4.pop_front();
            check("out_src4", 32'(src4), 32'(e4.src));
            check("out_data4", dout4, e4.data);
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b1 && ov3 && ordy3) begin
         if (sb3.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_word3: got src %0d data %h, expected none", src3, dout3);
         end else begin
            e3 = sb3.pop_front();
            check("out_src3", 32'(src3), 32'(e3.src));
            check("out_data3", dout3, e3.data);
         end
      end
   end

   // One cycle of M=4 stimulus; push_src < 0 means no transfer expected.
   task automatic c4(input logic md, input logic [1:0] s, input logic [3:0] v, input logic ordy,
                     input logic [3:0] exp_rdy, input int push_src);
      exp_t e;
      m4 = md; sel4 = s; vld4 = v; ordy4 = ordy;
      if (push_src >= 0) begin
         e.src  = 2'(push_src);
         e.data = d4[push_src];
         sb4.push_back(e);
      end
      @(negedge clk); #1;
      check("in_ready4", 32'(rdy4), 32'(exp_rdy));
      @(posedge clk); #1;
   endtask

   task automatic c3(input logic md, input logic [1:0] s, input logic [2:0] v, input logic ordy,
                     input logic [2:0] exp_rdy, input int push_src);
      exp_t e;
      m3 = md; sel3 = s; vld3 = v; ordy3 = ordy;
      if (push_src >= 0) begin
         e.src  = 2'(push_src);
         e.data = d3[push_src];
         sb3.push_back(e);
      end
      @(negedge clk); #1;
      check("in_ready3", 32'(rdy3), 32'(exp_rdy));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      d4[0] = 32'h1111_0000; d4[1] = 32'h2222_1111; d4[2] = 32'hDEAD_BEEF; d4[3] = 32'h4444_3333;
      d3[0] = 32'hA0A0_0000; d3[1] = 32'hB1B1_1111; d3[2] = 32'hC2C2_2222;
      din4 = {d4[3], d4[2], d4[1], d4[0]};
      din3 = {d3[2], d3[1], d3[0]};
      rst = 1'b0;
      m4 = 1'b0; sel4 = 2'd0; vld4 = 4'h0; ordy4 = 1'b1;
      m3 = 1'b0; sel3 = 2'd0; vld3 = 3'h0; ordy3 = 1'b1;
`ifdef ARB_MUX_LOCK_EN
      lock = 1'b0;
`endif

      // Reset state: fixed mode sel=0 would otherwise raise in_ready[0].
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("rst_out_valid", 32'(ov4), 32'd0);
      check("rst_out_data", dout4, 32'd0);
      check("rst_in_ready", 32'(rdy4), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Fixed mode, sel=2, one word per cycle.
      repeat (4) c4(1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 2);

      // Round-robin, all valid: 0,1,2,3,0.
      c4(1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 0);
      c4(1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1);
      c4(1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 2);
      c4(1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 3);
      c4(1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 0);

      // Round-robin, in_valid=1010: alternates 1,3.
      c4(1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1);
      c4(1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 3);
      c4(1'b1, 2'd0, 4'hA, 1'b1, 4'b0010, 1);
      c4(1'b1, 2'd0, 4'hA, 1'b1, 4'b1000, 3);

      // Backpressure for 5 cycles: word from channel 3 held.
      repeat (5) begin
         c4(1'b1, 2'd0, 4'hA, 1'b0, 4'b0000, -1);
         check("stall_valid", 32'(ov4), 32'd1);
         check("stall_src", 32'(src4), 32'd3);
         check("stall_data", dout4, d4[3]);
      end

      // Pop and reload in the same cycle.
      c4(1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1);
      check("no_bubble_valid", 32'(ov4), 32'd1);
      check("no_bubble_src", 32'(src4), 32'd1);
      c4(1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, -1);
      check("drain_valid", 32'(ov4), 32'd0);

      // M=3: fixed sel=0, then out-of-range sel=3.
      c3(1'b0, 2'd0, 3'b111, 1'b1, 3'b001, 0);
      c3(1'b0, 2'd3, 3'b111, 1'b1, 3'b000, -1);
      check("oor_valid3", 32'(ov3), 32'd0);
      // M=3 round-robin wrap 2 -> 0.
      c3(1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 0);
      c3(1'b1, 2'd0, 3'b111, 1'b1, 3'b010, 1);
      c3(1'b1, 2'd0, 3'b111, 1'b1, 3'b100, 2);
      c3(1'b1, 2'd0, 3'b111, 1'b1, 3'b001, 0);
      c3(1'b1, 2'd0, 3'b000, 1'b1, 3'b000, -1);
      c3(1'b0, 2'd0, 3'b000, 1'b1, 3'b001, -1);
      check("sb3_empty", 32'(sb3.size()), 32'd0);

      // Load channel 2 (ptr=2), stall, then reset mid-stall.
      c4(1'b1, 2'd0, 4'hF, 1'b0, 4'b0100, 2);
      c4(1'b1, 2'd0, 4'hF, 1'b0, 4'b0000, -1);
      check("pre_rst_valid", 32'(ov4), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_valid", 32'(ov4), 32'd0);
      check("mid_rst_data", dout4, 32'd0);
      check("mid_rst_src", 32'(src4), 32'd0);
      check("mid_rst_ready", 32'(rdy4), 32'd0);
      sb4.delete();
      @(posedge clk); #1;
      rst = 1'b1;

      // First round-robin grant after reset goes to channel 0.
      c4(1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 0);

`ifdef ARB_MUX_LOCK_EN
      c4(1'b1, 2'd0, 4'hF, 1'b1, 4'b0010, 1);
      c4(1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 2);
      lock = 1'b1;
      repeat (4) c4(1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 2);
      lock = 1'b0;
      c4(1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 3);
`endif

      c4(1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, -1);
      c4(1'b1, 2'd0, 4'h0, 1'b1, 4'b0000, -1);
      check("sb4_empty", 32'(sb4.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/n_bit_arb_mux.md
Name: n_bit_arb_mux

Overview:
- Parametrised successor to the fixed 4-way N-bit select: M-input, N-bit mux with a registered output and valid/ready handshakes.
- Two selection modes: fixed (external index) or round-robin among valid inputs.
- Used wherever several producers share one datapath, e.g. the writeback-source merge or the memory-request port shared by fetch and load/store.
- One-cycle latency, full throughput of 1 transfer per cycle.

Parameters:
- N, 32, data width of each input and of the output.
- M, 4, number of input channels; M >= 2, not required to be a power of two.
- SELW, clog2(M), localparam; width of sel and out_src.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- in_data  input  M*N  channel i occupies bits [i*N+N-1 : i*N].
- in_valid  input  M  per-channel valid.
- in_ready  output  M  per-channel ready; at most one bit set.
- out_data  output  N  registered selected data.
- out_valid  output  1  out_data holds an untaken word.
- out_ready  input  1  downstream accepts when high with out_valid.
- out_src  output  SELW  index of the channel that produced out_data.

Behaviour:
- Reset (rst low, asynchronous): out_valid=0, out_data=0, out_src=0, rr pointer ptr=0. in_ready is 0 while rst is low.
- load = !out_valid | out_ready. The output register may accept a new word in any cycle where load is high.
- Grant g (combinational):
  - Fixed mode: g = sel if sel < M; otherwise there is no grant.
  - Round-robin mode: g is the first i with in_valid[i], searched ptr, ptr+1, ... with wrap M-1 -> 0. No grant if in_valid == 0.
- in_ready[i] = load & (i == g); combinationally dependent on in_valid/mode/sel. Fixed mode raises in_ready[sel] even when in_valid[sel] = 0.
- Transfer on channel i when in_valid[i] & in_ready[i].
- On a clock edge:
  - Transfer: out_data <= in_data[g], out_src <= g, out_valid <= 1.
  - No transfer and out_ready: out_valid <= 0; out_data and out_src hold.
  - Otherwise: hold everything.
- Round-robin pointer:
  - Round-robin transfer: ptr <= (g == M-1) ? 0 : g+1.
  - Fixed-mode transfer, or no transfer: ptr holds.
- Simultaneous downstream pop and upstream transfer in the same cycle is the normal back-to-back case; there is no bubble.
- Stall (out_valid & !out_ready): all in_ready = 0 and out_data/out_src are stable. Mode and sel changes during a stall affect only the next grant.
- Mode switch takes effect in the same cycle's grant. The word already in the output register is unaffected.
- Reset mid-stall discards the held word: out_valid drops asynchronously.

Optional Feature:
- Macro: ARB_MUX_LOCK_EN.
- Enabled:
  - Adds input port lock (1 bit).
  - In round-robin mode, while lock is high and at least one round-robin transfer has occurred since reset, grant is forced to last_src (register updated on every round-robin transfer) even if that channel is not valid.
  - ptr holds while locked.
  - Supports multi-beat bursts. lock has no effect in fixed mode.
- Disabled: no lock port, no last_src register; behaviour exactly as above.

Decomposition:
- Package arb_mux_pkg:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1.
  - clog2 constant function used for SELW.
- Sub-module rr_priority_pick: purely combinational rotate-priority encoder.
  - Inputs: req[M], ptr[SELW].
  - Outputs: gnt_idx[SELW], gnt_any.
  - Instantiated once. Top level holds the output register, ptr and the handshake logic.

Test Plan:
- Reset: assert rst=0 mid-traffic with out_valid=1 -> out_valid, out_data, out_src go to 0 immediately, in_ready=0; after release the first RR grant goes to channel 0.
- Fixed mode, N=32, M=4, sel=2, in_data[2]=0xDEADBEEF, in_valid=4'b1111, out_ready=1 -> next cycle out_data=0xDEADBEEF, out_src=2. in_ready=4'b0100 every cycle; one word per cycle.
- Fixed mode, M=3, sel=3 (out of range), all valid -> in_ready=0, out_valid falls to 0 after the pending word drains.
- Round-robin, all 4 valid, out_ready=1 -> out_src sequence 0,1,2,3,0,... Then in_valid=4'b1010 -> alternates 1,3. With M=3 -> wrap 2->0 is verified.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles -> out_data/out_src stable, in_ready=0. Raise out_ready with in_valid[1]=1 -> pop and new load in the same cycle, no bubble.
- ARB_MUX_LOCK_EN: RR grant to channel 2, lock=1, all valid for 4 cycles -> out_src=2 for 4 words. Drop lock -> next out_src=3.
